// File: rtl/vector_wb_queue.sv
// vector_wb_queue
//   Writeback collector behind the vector ALU. Results from the VSFX, VCFX
//   and VFPU pipes (latencies 1, 3 and 4) can complete in the same cycle.
//   They are queued in program order and drained one per cycle into the
//   vector register file write port, with the SAT and CR6 side-band.
//   wb_stall holds the issue stage, because the ALU pipes cannot stall.
//
// Ports
//   clk, rst             clock, asynchronous active-high reset
//   vsfx_*               VSFX result: en, reg, data, sat, cr_upd, cr6
//   vcfx_*               VCFX result: en, reg, data, sat
//   vfpu_*               VFPU result: en, reg, data (SAT is always 0)
//   rf_we/waddr/wdata    register-file write port, driven by the head entry
//   vscr_en, vscr_sat    SAT update strobe (same as rf_we) and value
//   cr_en, cr_data       CR6 update strobe and value
//   wb_stall             occupancy >= STALL_TH
//   q_count              current occupancy
//   ovf_err              sticky flag, set when a result had to be dropped
//
// Parameters
//   DEPTH    queue entries; power of two, at least 8
//   STALL_TH must be <= DEPTH-4, because up to 4 results can already be in
//            flight when the stall is seen
module vector_wb_queue #(
   parameter int DEPTH    = 8,
   parameter int STALL_TH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     vsfx_en,
   input  logic [4:0]               vsfx_reg,
   input  logic [0:127]             vsfx_data,
   input  logic                     vsfx_sat,
   input  logic                     vsfx_cr_upd,
   input  logic [3:0]               vsfx_cr6,
   input  logic                     vcfx_en,
   input  logic [4:0]               vcfx_reg,
   input  logic [0:127]             vcfx_data,
   input  logic                     vcfx_sat,
   input  logic                     vfpu_en,
   input  logic [4:0]               vfpu_reg,
   input  logic [0:127]             vfpu_data,
   output logic                     rf_we,
   output logic [4:0]               rf_waddr,
   output logic [0:127]             rf_wdata,
   output logic                     vscr_en,
   output logic                     vscr_sat,
   output logic                     cr_en,
   output logic [3:0]               cr_data,
   output logic                     wb_stall,
   output logic [$clog2(DEPTH):0]   q_count,
   output logic                     ovf_err
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;   // count and pointers (extra wrap bit)
   localparam int FW = AW + 2;   // free-slot arithmetic, holds DEPTH+1

   typedef struct packed {
      logic [4:0]   rg;
      logic [0:127] data;
      logic         sat;
      logic         cr_vld;
      logic [3:0]   cr6;
   } wb_entry_t;

   wb_entry_t       mem [DEPTH];
   logic [CW-1:0]   wr_ptr, rd_ptr, count;

   // Candidates in push priority: 0 = VFPU (oldest), 1 = VCFX, 2 = VSFX.
   // A longer-latency result finishing in the same cycle was issued earlier.
   wb_entry_t       cand [3];
   logic [2:0]      cand_v;
   logic [1:0]      pos  [3];
   logic [2:0]      acc;
   logic [1:0]      n_push;
   logic            pop;
   logic [FW-1:0]   free;
   logic            drop;
   wb_entry_t       head;

   always_comb begin
      cand[0] = '{rg: vfpu_reg, data: vfpu_data, sat: 1'b0,
                  cr_vld: 1'b0, cr6: 4'b0};
      cand[1] = '{rg: vcfx_reg, data: vcfx_data, sat: vcfx_sat,
                  cr_vld: 1'b0, cr6: 4'b0};
      cand[2] = '{rg: vsfx_reg, data: vsfx_data, sat: vsfx_sat,
                  cr_vld: vsfx_cr_upd, cr6: vsfx_cr6};
      cand_v  = {vsfx_en, vcfx_en, vfpu_en};

      // Pop is decided on the current count, so a full queue that pops
      // can still accept one new result this cycle.
      pop  = (count != '0);
      free = FW'(DEPTH) - FW'(count) + FW'(pop);

      // Each valid candidate takes the next consecutive slot; anything that
      // lands beyond the free space is dropped, VSFX going first.
      pos[0] = 2'd0;
      pos[1] = {1'b0, cand_v[0]};
      pos[2] = {1'b0, cand_v[0]} + {1'b0, cand_v[1]};
      for (int k = 0; k < 3; k++)
         acc[k] = cand_v[k] && (FW'(pos[k]) < free);
      n_push = {1'b0, acc[0]} + {1'b0, acc[1]} + {1'b0, acc[2]};
      drop   = |(cand_v & ~acc);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         ovf_err <= 1'b0;
      end else begin
         wr_ptr  <= wr_ptr + CW'(n_push);
         rd_ptr  <= rd_ptr + CW'(pop);
         count   <= count + CW'(n_push) - CW'(pop);
         if (drop)
            ovf_err <= 1'b1;
      end
   end

   // Entry storage is not reset; slots beyond the occupancy are never read out.
   always_ff @(posedge clk) begin
      for (int k = 0; k < 3; k++)
         if (acc[k])
            mem[wr_ptr[AW-1:0] + AW'(pos[k])] <= cand[k];
   end

   // Outputs come straight from the head entry and read 0 while empty.
   always_comb begin
      head     = mem[rd_ptr[AW-1:0]];
      rf_we    = pop;
      rf_waddr = pop ? head.rg   : 5'd0;
      rf_wdata = pop ? head.data : '0;
      vscr_en  = pop;
      vscr_sat = pop & head.sat;
      cr_en    = pop & head.cr_vld;
      cr_data  = pop ? head.cr6  : 4'd0;
      wb_stall = (count >= CW'(STALL_TH));
      q_count  = count;
   end

endmodule
